// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder: datapath plus controller. Two WIDTH-bit operands are
// captured on an accepted start, then added LSB-first one bit per clock through
// a single full-adder slice. The running carry lives in a 1-bit register. Each
// sum bit is shifted into the result register from the MSB end. Completion is
// flagged with a one-cycle done pulse.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   rst    - synchronous, active-high reset (priority over everything)
//   start  - begin an addition; only looked at while idle
//   a, b   - WIDTH-bit operands, captured on the accept edge
//   cin    - initial carry-in, captured on the accept edge
//   sum    - result register, holds the last completed sum
//   cout   - final carry-out, held alongside sum
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when sum/cout are valid
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             sliceSum;
  logic             sliceCarry;
  logic             lastBit;

  // The single full-adder slice always looks at the LSBs of the operand
  // shift registers and at the carry flop's q; its carry output is the
  // carry flop's d while running.
  assign sliceSum   = aSh_q[0] ^ bSh_q[0] ^ carry_q;
  assign sliceCarry = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);
  assign lastBit    = (count_q == LastCount);

  // All state, including the datapath registers, updates here. Reset is
  // synchronous and wipes any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state logic. start only matters in IDLE; DONE always lasts a single
  // cycle, so a start seen there is dropped rather than queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. The counter holds at its final value on the last
  // bit instead of incrementing, so it never wraps even when 2^CW == WIDTH.
  always_comb begin
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    carry_d = carry_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aSh_d   = a;
          bSh_d   = b;
          carry_d = cin;
          count_d = '0;
        end
      end
      RUN: begin
        carry_d = sliceCarry;
        sum_d   = {sliceSum, sum_q[WIDTH-1:1]};
        aSh_d   = {1'b0, aSh_q[WIDTH-1:1]};
        bSh_d   = {1'b0, bSh_q[WIDTH-1:1]};
        if (lastBit) begin
          cout_d = sliceCarry;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Status outputs are pure decodes of the registered state, so there is no
  // combinational path from start to busy/done.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Drives an 8-bit and a 4-bit instance of serial_adder_ctrl. A behavioural
// model predicts busy/done/sum/cout for every cycle from the arithmetic result
// and the number of edges since the accepting start. Directed scenarios add
// literal expectations on top.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, busy8, done8;

  logic       start4, cin4;
  logic [3:0] a4, b4, sum4;
  logic       cout4, busy4, done4;

  int vectors     = 0;
  int miscompares = 0;

  // 10 ns clock period.
  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8), .CW(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  // The 4-bit instance uses the tightest legal counter width (2^CW == WIDTH).
  serial_adder_ctrl #(.WIDTH(4), .CW(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model state, index 0 = 8-bit instance, index 1 = 4-bit instance.
  // mStep is the number of edges since the accept edge (-1 = idle). Bits
  // come out at steps 1..W, busy covers steps 0..W-1, and done is step W.
  int  dutWidth[2] = '{8, 4};
  int  mStep[2];
  int  mSum[2];
  int  mCout[2];
  int  mOld[2];
  int  mRes[2];
  bit  modelValid = 1'b0;

  // Model update at each rising edge. The result comes from a + b + cin.
  // Mid-run, sum is the old value shifted right by k, with the low k result
  // bits sitting at the top.
  always @(posedge clk) begin : modelUpdate
    int stIn[2], aIn[2], bIn[2], cIn[2];
    int w, k, mask;
    stIn[0] = int'(start8); aIn[0] = int'(a8); bIn[0] = int'(b8); cIn[0] = int'(cin8);
    stIn[1] = int'(start4); aIn[1] = int'(a4); bIn[1] = int'(b4); cIn[1] = int'(cin4);
    for (int d = 0; d < 2; d++) begin
      w    = dutWidth[d];
      mask = (1 << w) - 1;
      if (rst) begin
        mStep[d] = -1;
        mSum[d]  = 0;
        mCout[d] = 0;
      end else if (mStep[d] < 0) begin
        if (stIn[d] != 0) begin
          mStep[d] = 0;
          mOld[d]  = mSum[d];
          mRes[d]  = aIn[d] + bIn[d] + cIn[d];
        end
      end else if (mStep[d] < w) begin
        mStep[d] = mStep[d] + 1;
        k        = mStep[d];
        mSum[d]  = ((mOld[d] >> k) | ((mRes[d] & ((1 << k) - 1)) << (w - k))) & mask;
        if (k == w) mCout[d] = (mRes[d] >> w) & 1;
      end else begin
        mStep[d] = -1;
      end
    end
    if (rst) modelValid = 1'b1;
  end

  // Every-cycle comparison of both instances against the model, sampled on
  // the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("busy8", busy8, (mStep[0] >= 0) && (mStep[0] < 8));
      checkOutput("done8", done8, mStep[0] == 8);
      checkOutput("sum8",  sum8,  mSum[0]);
      checkOutput("cout8", cout8, mCout[0]);
      checkOutput("busy4", busy4, (mStep[1] >= 0) && (mStep[1] < 4));
      checkOutput("done4", done4, mStep[1] == 4);
      checkOutput("sum4",  sum4,  mSum[1]);
      checkOutput("cout4", cout4, mCout[1]);
    end
  end

  // Pulse start on the 8-bit instance for one edge, then watch until done.
  // The loop is bounded. busyCnt counts busy samples; doneAt is the sample
  // index of done, with 1 being the sample right after the accept edge and
  // 0 meaning done was never seen.
  task automatic applyStimulus(input logic [7:0] aV, input logic [7:0] bV, input logic cV,
                               output int busyCnt, output int doneAt);
    busyCnt = 0;
    doneAt  = 0;
    start8  = 1'b1;
    a8      = aV;
    b8      = bV;
    cin8    = cV;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) busyCnt++;
      if (done8) begin
        doneAt = i;
        break;
      end
    end
  endtask

  initial begin : stimulus
    int busyCnt, doneAt, seen, nDone, lastDone, got;
    logic [4:0] expect4;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, then idle with wiggling operands but no start.
    @(negedge clk);
    checkOutput("rst_sum", sum8, 8'h00);
    checkOutput("rst_cout", cout8, 0);
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_done", done8, 0);
    for (int i = 0; i < 4; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
    end
    checkOutput("idle_busy", busy8, 0);

    // 0x0F + 0x01: busy for 8 samples, done on the 9th, sum 0x10.
    applyStimulus(8'h0F, 8'h01, 1'b0, busyCnt, doneAt);
    checkOutput("t2_busy_cycles", busyCnt, 8);
    checkOutput("t2_done_at", doneAt, 9);
    checkOutput("t2_sum", sum8, 8'h10);
    checkOutput("t2_cout", cout8, 0);
    @(negedge clk);
    checkOutput("t2_done_pulse", done8, 0);

    // Carry out of the top bit, and the all-ones case with carry-in.
    applyStimulus(8'hFF, 8'h01, 1'b0, busyCnt, doneAt);
    checkOutput("t3a_sum", sum8, 8'h00);
    checkOutput("t3a_cout", cout8, 1);
    @(negedge clk);
    applyStimulus(8'hFF, 8'hFF, 1'b1, busyCnt, doneAt);
    checkOutput("t3b_sum", sum8, 8'hFF);
    checkOutput("t3b_cout", cout8, 1);
    repeat (3) @(negedge clk);
    checkOutput("t3b_hold_sum", sum8, 8'hFF);
    checkOutput("t3b_hold_cout", cout8, 1);

    // start pulses during RUN and during DONE are ignored.
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(negedge clk);
    start8 = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t4_done_seen", seen, 1);
    checkOutput("t4_sum", sum8, 8'h46);
    checkOutput("t4_cout", cout8, 0);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("t4_start_in_done_ignored", busy8, 0);
    @(negedge clk);
    checkOutput("t4_still_idle", busy8, 0);

    // Reset in the 4th RUN cycle discards the partial result.
    start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_rst_sum", sum8, 8'h00);
    checkOutput("t5_rst_cout", cout8, 0);
    checkOutput("t5_rst_busy", busy8, 0);
    checkOutput("t5_rst_done", done8, 0);
    @(negedge clk);
    applyStimulus(8'hF0, 8'h0F, 1'b1, busyCnt, doneAt);
    checkOutput("t5_sum", sum8, 8'h00);
    checkOutput("t5_cout", cout8, 1);
    @(negedge clk);

    // start held high: back-to-back additions, done every WIDTH+2 cycles.
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    nDone = 0;
    lastDone = 0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (done8) begin
        if (nDone > 0) checkOutput("t6_done_interval", i - lastDone, 10);
        checkOutput("t6_sum", sum8, 8'h00);
        checkOutput("t6_cout", cout8, 1);
        nDone++;
        lastDone = i;
      end
    end
    start8 = 1'b0;
    checkOutput("t6_done_count", nDone, 3);
    repeat (12) @(negedge clk);

    // Exhaustive sweep of the 4-bit instance against plain arithmetic.
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          start4 = 1'b1; a4 = 4'(av); b4 = 4'(bv); cin4 = 1'(cv);
          seen = 0;
          for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (done4) begin
              seen = 1;
              break;
            end
          end
          expect4 = 5'(av + bv + cv);
          got = int'({cout4, sum4});
          checkOutput("sweep4_done_seen", seen, 1);
          checkOutput("sweep4_result", got, expect4);
          @(negedge clk);
        end
      end
    end

    // Random traffic on both instances, including starts during RUN/DONE
    // and occasional resets; the model checks every cycle.
    for (int i = 0; i < 800; i++) begin
      start8 = ($urandom_range(0, 2) == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      start4 = ($urandom_range(0, 2) == 0);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
